// File: rtl/minterm_sweep_checker.sv
// Drives all eight {A,B,C} vectors into a 3-input function block, captures F per vector
// and compares the measured truth table against EXPECTED. Optional macro: MINTERM_SWEEP_ERRCNT_EN.
module minterm_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  EXPECTED      = 8'h03
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [7:0] mismatch_mask,
    output logic       match
`ifdef MINTERM_SWEEP_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] shadow;
    logic [7:0] sampled_table;

    // Shadow table with the current vector's bit replaced by f_in; this is what
    // gets published when the final vector is sampled.
    always_comb begin
        sampled_table      = shadow;
        sampled_table[idx] = f_in;
    end

    // NOTE: all state uses non-blocking assignments so every register sees the
    // pre-edge values of the others; the shadow table is reset like any other
    // register because it is tiny and its reset value is observable behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= 3'd0;
            cnt           <= 4'd0;
            shadow        <= 8'h00;
            abc_out       <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_out     <= 8'h00;
            mismatch_mask <= 8'h00;
            match         <= 1'b0;
`ifdef MINTERM_SWEEP_ERRCNT_EN
            err_cnt       <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_HOLD;
                        idx     <= 3'd0;
                        cnt     <= SETTLE;
                        busy    <= 1'b1;
                        abc_out <= 3'd0;
                    end
                end
                ST_HOLD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        shadow <= sampled_table;
                        if (idx == 3'd7) begin
                            state         <= ST_DONE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            abc_out       <= 3'd0;
                            table_out     <= sampled_table;
                            mismatch_mask <= sampled_table ^ EXPECTED;
                            match         <= (sampled_table == EXPECTED);
`ifdef MINTERM_SWEEP_ERRCNT_EN
                            if ((sampled_table != EXPECTED) && (err_cnt != 8'hFF))
                                err_cnt <= err_cnt + 8'd1;
`endif
                        end else begin
                            // Next vector goes out on the same edge that samples this one.
                            idx     <= idx + 3'd1;
                            abc_out <= idx + 3'd1;
                            cnt     <= SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench for minterm_sweep_checker: table-driven sweeps at SETTLE_CYCLES=1 plus
// hand-written abort, ignored-start and back-to-back (SETTLE_CYCLES=0) sequences.
module tb_minterm_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start0;
    logic [7:0] mask1, mask0;
    logic       f1, f0;
    logic [2:0] abc1, abc0;
    logic       busy1, busy0, done1, done0, match1, match0;
    logic [7:0] table1, table0, mm1, mm0;
`ifdef MINTERM_SWEEP_ERRCNT_EN
    logic [7:0] err1, err0;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Function block model: F is the mask bit selected by the current {A,B,C}.
    assign f1 = mask1[abc1];
    assign f0 = mask0[abc0];

    minterm_sweep_checker #(.SETTLE_CYCLES(1), .EXPECTED(8'h03)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f1), .abc_out(abc1),
        .busy(busy1), .done(done1), .table_out(table1), .mismatch_mask(mm1),
        .match(match1)
`ifdef MINTERM_SWEEP_ERRCNT_EN
        , .err_cnt(err1)
`endif
    );

    minterm_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(8'h03)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f0), .abc_out(abc0),
        .busy(busy0), .done(done0), .table_out(table0), .mismatch_mask(mm0),
        .match(match0)
`ifdef MINTERM_SWEEP_ERRCNT_EN
        , .err_cnt(err0)
`endif
    );

    typedef struct {
        logic [7:0] func;
        logic [7:0] exp_table;
        logic [7:0] exp_mm;
        logic       exp_match;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one sweep on dut1 (S=1); returns the edge count from the start edge to done.
    task automatic sweep1(input logic [7:0] m, input bit chk_abc, output int k_done);
        mask1 = m;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("busy_after_start", 32'(busy1), 32'd1);
        k_done = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                k_done = k;
                break;
            end
            if (chk_abc) check("abc_step", 32'(abc1), 32'(k / 2));
        end
        check("done_latency", 32'(k_done), 32'd16);
        check("busy_in_done", 32'(busy1), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done1), 32'd0);
    endtask

    initial begin
        int k_done;
        int dones;
        int t_done[3];
        bit stable;
        bit tbl_held;

        vecs[0] = '{func: 8'h03, exp_table: 8'h03, exp_mm: 8'h00, exp_match: 1'b1};
        vecs[1] = '{func: 8'hFF, exp_table: 8'hFF, exp_mm: 8'hFC, exp_match: 1'b0};
        vecs[2] = '{func: 8'h00, exp_table: 8'h00, exp_mm: 8'h03, exp_match: 1'b0};
        vecs[3] = '{func: 8'hA5, exp_table: 8'hA5, exp_mm: 8'hA6, exp_match: 1'b0};
        vecs[4] = '{func: 8'h02, exp_table: 8'h02, exp_mm: 8'h01, exp_match: 1'b0};

        rst = 1'b1; start1 = 1'b0; start0 = 1'b0; mask1 = 8'h00; mask0 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_abc", 32'(abc1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_table", 32'(table1), 32'd0);
        check("rst_mm", 32'(mm1), 32'd0);
        check("rst_match", 32'(match1), 32'd0);
        check("rst_table_s0", 32'(table0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_start", 32'(busy1), 32'd0);

        // Table-driven sweeps; the first also walks abc_out through every vector.
        for (int i = 0; i < 5; i++) begin
            sweep1(vecs[i].func, (i == 0), k_done);
            check("table_out", 32'(table1), 32'(vecs[i].exp_table));
            check("mismatch_mask", 32'(mm1), 32'(vecs[i].exp_mm));
            check("match", 32'(match1), 32'(vecs[i].exp_match));
        end

        // start pulsed while vector 3 is driven: ignored, one done, old table held until then.
        mask1 = 8'h81;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        dones = 0; tbl_held = 1'b1; k_done = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            if (k == 6) begin
                check("abc_at_restart", 32'(abc1), 32'd3);
                start1 = 1'b1;
            end
            if (done1) begin
                dones++;
                if (k_done < 0) k_done = k;
            end
            if (dones == 0 && table1 !== 8'h02) tbl_held = 1'b0;
        end
        check("restart_ignored_dones", 32'(dones), 32'd1);
        check("restart_done_latency", 32'(k_done), 32'd16);
        check("table_held_until_done", 32'(tbl_held), 32'd1);
        check("restart_table", 32'(table1), 32'h81);
        check("restart_mm", 32'(mm1), 32'h82);

        // Reset while abc_out=4: immediate return to reset values, no done afterwards.
        mask1 = 8'hFF;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abc_before_abort", 32'(abc1), 32'd4);
        rst = 1'b1;
        #1;
        check("abort_abc", 32'(abc1), 32'd0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_table", 32'(table1), 32'd0);
        check("abort_mm", 32'(mm1), 32'd0);
        check("abort_match", 32'(match1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
`ifdef MINTERM_SWEEP_ERRCNT_EN
        check("abort_err_cnt", 32'(err1), 32'd0);
`endif

        // Stuck-at-1 after reset; error counter steps 0 -> 1.
        sweep1(8'hFF, 1'b0, k_done);
        check("stuck1_table", 32'(table1), 32'hFF);
        check("stuck1_mm", 32'(mm1), 32'hFC);
        check("stuck1_match", 32'(match1), 32'd0);
`ifdef MINTERM_SWEEP_ERRCNT_EN
        check("stuck1_err_cnt", 32'(err1), 32'd1);
`endif

        // S=0 with start held: done every 10 cycles, outputs stable between pulses.
        mask0 = 8'h03;
        @(negedge clk);
        start0 = 1'b1;
        dones = 0; stable = 1'b1;
        for (int c = 1; c <= 200 && dones < 3; c++) begin
            @(posedge clk);
            #1;
            if (dones > 0 && (table0 !== 8'h03 || mm0 !== 8'h00 || match0 !== 1'b1)) stable = 1'b0;
            if (done0) begin
                t_done[dones] = c;
                dones++;
            end
        end
        check("held_done_count", 32'(dones), 32'd3);
        check("held_first_done", 32'(t_done[0]), 32'd9);
        check("held_period_1", 32'(t_done[1] - t_done[0]), 32'd10);
        check("held_period_2", 32'(t_done[2] - t_done[1]), 32'd10);
        check("held_outputs_stable", 32'(stable), 32'd1);

`ifdef MINTERM_SWEEP_ERRCNT_EN
        // Switch to a failing function right after a done so no sweep mixes masks.
        mask0 = 8'h00;
        check("err_cnt_before_sat", 32'(err0), 32'd0);
        dones = 0;
        for (int c = 0; c < 2800 && dones < 260; c++) begin
            @(posedge clk);
            #1;
            if (done0) dones++;
        end
        check("sat_sweeps", 32'(dones), 32'd260);
        check("err_cnt_saturated", 32'(err0), 32'hFF);
`endif
        start0 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
